// File: rtl/idvr_shift_issue.sv
// rtl/idvr_shift_issue.sv - shift issue stage: one-deep request register feeding an external shifter, 2-entry result FIFO
//
// Purpose:
//    Accepts shift requests on a valid/ready handshake. The request is held in
//    stage 1 (S1), whose contents drive the external combinational shifter. The
//    shifter result is captured into a 2-entry output FIFO. Illegal ops
//    (IOP == 2'b10) are counted in a saturating counter.
//
// Configuration macro:
//    IDVR_SHIFT_ERRDROP_EN - when defined, illegal requests are counted and then
//    dropped at S1 instead of entering the output FIFO.
//
// Ports:
//    CLK     in   clock, rising edge
//    RST     in   synchronous active-high reset
//    IV/IR   in/out request valid / ready
//    IA      in   operand, W bits
//    IB      in   shift amount source, low TW bits used
//    IOP     in   00 SLL, 01 SRL, 11 SRA, 10 illegal
//    SI      out  operand to shifter (from S1)
//    SSHAMT  out  shift amount to shifter (from S1)
//    SS      out  op to shifter (from S1)
//    SO      in   shifter result
//    SERR    in   shifter illegal flag
//    OV/ORDY out/in result valid / downstream ready
//    OD      out  result data (FIFO head)
//    OE      out  result illegal-op flag (FIFO head)
//    ECNT    out  saturating count of accepted illegal requests
module idvr_shift_issue #(
   parameter int W  = 32,
   parameter int TW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IV,
   output logic          IR,
   input  logic [W-1:0]  IA,
   input  logic [W-1:0]  IB,
   input  logic [1:0]    IOP,
   output logic [W-1:0]  SI,
   output logic [TW-1:0] SSHAMT,
   output logic [1:0]    SS,
   input  logic [W-1:0]  SO,
   input  logic          SERR,
   output logic          OV,
   input  logic          ORDY,
   output logic [W-1:0]  OD,
   output logic          OE,
   output logic [7:0]    ECNT
);

   localparam logic [1:0] OP_ILL = 2'b10;

   logic          s1_v_q, s1_v_d;
   logic [W-1:0]  s1_a_q, s1_a_d;
   logic [TW-1:0] s1_sh_q, s1_sh_d;
   logic [1:0]    s1_op_q, s1_op_d;

   logic [W-1:0]  mem_data_q [2];
   logic [W-1:0]  mem_data_d [2];
   logic          mem_err_q  [2];
   logic          mem_err_d  [2];
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [1:0]    cnt_q, cnt_d;

   // Last popped head, shown on OD/OE while the FIFO is empty so the
   // outputs never expose a stale slot that was never the head.
   logic [W-1:0]  last_data_q, last_data_d;
   logic          last_err_q, last_err_d;

   logic [7:0]    ecnt_q, ecnt_d;

   logic          pop, s1_move, accept, push, s1_ill;
   logic [W-1:0]  push_data;
   logic          push_err;

   logic          ib_unused;
   assign ib_unused = ^IB[W-1:TW];

   always_comb begin
      pop     = (cnt_q != 2'd0) && ORDY;
      s1_move = s1_v_q && ((cnt_q != 2'd2) || pop);
      IR      = !RST && (!s1_v_q || s1_move);
      accept  = IV && IR;
      s1_ill  = (s1_op_q == OP_ILL);
`ifdef IDVR_SHIFT_ERRDROP_EN
      push    = s1_move && !s1_ill;
`else
      push    = s1_move;
`endif
      // Illegal ops pass the operand through regardless of what the shifter returns.
      push_data = s1_ill ? s1_a_q : SO;
      push_err  = SERR || s1_ill;

      s1_v_d      = s1_v_q;
      s1_a_d      = s1_a_q;
      s1_sh_d     = s1_sh_q;
      s1_op_d     = s1_op_q;
      mem_data_d  = mem_data_q;
      mem_err_d   = mem_err_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      last_data_d = last_data_q;
      last_err_d  = last_err_q;
      ecnt_d      = ecnt_q;

      if (accept) begin
         s1_v_d  = 1'b1;
         s1_a_d  = IA;
         s1_sh_d = IB[TW-1:0];
         s1_op_d = IOP;
      end else if (s1_move) begin
         s1_v_d = 1'b0;
      end

      // When full, wr == rd: the write lands in the slot being popped this cycle.
      if (push) begin
         mem_data_d[wr_q] = push_data;
         mem_err_d[wr_q]  = push_err;
         wr_d             = ~wr_q;
      end

      if (pop) begin
         last_data_d = mem_data_q[rd_q];
         last_err_d  = mem_err_q[rd_q];
         rd_d        = ~rd_q;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      if (accept && (IOP == OP_ILL) && (ecnt_q != 8'hFF)) begin
         ecnt_d = ecnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_v_q        <= 1'b0;
         s1_a_q        <= '0;
         s1_sh_q       <= '0;
         s1_op_q       <= '0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_err_q[0]  <= 1'b0;
         mem_err_q[1]  <= 1'b0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         cnt_q         <= 2'd0;
         last_data_q   <= '0;
         last_err_q    <= 1'b0;
         ecnt_q        <= 8'd0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_a_q      <= s1_a_d;
         s1_sh_q     <= s1_sh_d;
         s1_op_q     <= s1_op_d;
         mem_data_q  <= mem_data_d;
         mem_err_q   <= mem_err_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         last_data_q <= last_data_d;
         last_err_q  <= last_err_d;
         ecnt_q      <= ecnt_d;
      end
   end

   assign SI     = s1_a_q;
   assign SSHAMT = s1_sh_q;
   assign SS     = s1_op_q;
   assign OV     = (cnt_q != 2'd0);
   assign OD     = OV ? mem_data_q[rd_q] : last_data_q;
   assign OE     = OV ? mem_err_q[rd_q]  : last_err_q;
   assign ECNT   = ecnt_q;

endmodule

// File: tb/tb_idvr_shift_issue.sv
// tb/tb_idvr_shift_issue.sv - self-checking bench for idvr_shift_issue
module tb_idvr_shift_issue;

   localparam int W  = 8;
   localparam int TW = 5;

   logic          CLK = 1'b0;
   logic          RST, IV, IR;
   logic [W-1:0]  IA, IB, SI, SO, OD;
   logic [1:0]    IOP, SS;
   logic [TW-1:0] SSHAMT;
   logic          SERR, OV, ORDY, OE;
   logic [7:0]    ECNT;

   int            total = 0;
   int            bad   = 0;
   bit            acc_last;
   logic [8:0]    sb_q [$];

   always #5 CLK = ~CLK;

   idvr_shift_issue #(.W(W), .TW(TW)) dut (
      .CLK(CLK), .RST(RST), .IV(IV), .IR(IR), .IA(IA), .IB(IB), .IOP(IOP),
      .SI(SI), .SSHAMT(SSHAMT), .SS(SS), .SO(SO), .SERR(SERR),
      .OV(OV), .ORDY(ORDY), .OD(OD), .OE(OE), .ECNT(ECNT)
   );

   // External shifter; returns zero for the illegal op so the design's
   // operand pass-through is what produces OD on illegal requests.
   always_comb begin
      case (SS)
         2'b00:   SO = SI << SSHAMT;
         2'b01:   SO = SI >> SSHAMT;
         2'b11:   SO = W'($signed(SI) >>> SSHAMT);
         default: SO = '0;
      endcase
      SERR = (SS == 2'b10);
   end

   function automatic logic [8:0] expect_res(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
      logic [4:0] sh;
      logic [7:0] r;
      sh = b[4:0];
      case (op)
         2'b00:   r = a << sh;
         2'b01:   r = a >> sh;
         2'b11:   r = 8'($signed(a) >>> sh);
         default: r = a;
      endcase
      return {op == 2'b10, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [8:0] e;
      @(negedge CLK);
      acc_last = IV && IR;
      if (acc_last) begin
         e = expect_res(IA, IB, IOP);
`ifdef IDVR_SHIFT_ERRDROP_EN
         if (IOP != 2'b10) sb_q.push_back(e);
`else
         sb_q.push_back(e);
`endif
      end
      if (OV && ORDY) begin
         total++;
         assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_output observed=%0h expected=none", OD);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pop_od", 32'(OD), 32'(e[7:0]));
            chk("pop_oe", 32'(OE), 32'(e[8]));
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      IV   = 1'b0;
      ORDY = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if (sb_q.size() == 0 && !OV) break;
         cycle();
      end
      chk("drain_done", 32'(sb_q.size() == 0 && !OV), 32'd1);
   endtask

   initial begin
      int n;
      RST = 1'b1; IV = 1'b0; IA = '0; IB = '0; IOP = 2'b00; ORDY = 1'b1;
      @(posedge CLK); #1;
      cycle();
      cycle();
      chk("rst_ir", 32'(IR), 32'd0);
      chk("rst_ov", 32'(OV), 32'd0);
      chk("rst_od", 32'(OD), 32'd0);
      chk("rst_oe", 32'(OE), 32'd0);
      chk("rst_ecnt", 32'(ECNT), 32'd0);
      RST = 1'b0;
      #1;
      chk("post_rst_ir", 32'(IR), 32'd1);

      // Single SLL, latency 2
      IV = 1'b1; IA = 8'h81; IB = 8'h01; IOP = 2'b00;
      cycle();
      chk("sll_acc", 32'(acc_last), 32'd1);
      IV = 1'b0;
      chk("sll_k1_ov", 32'(OV), 32'd0);
      cycle();
      chk("sll_k2_ov", 32'(OV), 32'd1);
      chk("sll_k2_od", 32'(OD), 32'h02);
      chk("sll_k2_oe", 32'(OE), 32'd0);
      cycle();
      chk("empty_ov", 32'(OV), 32'd0);
      chk("empty_od_hold", 32'(OD), 32'h02);

      // Back-to-back SRL / SRA with masked shift amount
      IV = 1'b1; IA = 8'h81; IB = 8'h21; IOP = 2'b01;
      cycle();
      IOP = 2'b11;
      cycle();
      IV = 1'b0;
      chk("srl_ov", 32'(OV), 32'd1);
      chk("srl_od", 32'(OD), 32'h40);
      cycle();
      chk("sra_ov", 32'(OV), 32'd1);
      chk("sra_od", 32'(OD), 32'hC0);
      cycle();
      chk("b2b_done_ov", 32'(OV), 32'd0);

      // Backpressure: 3 accepted, 4th stalls until ORDY returns
      ORDY = 1'b0;
      n = 0;
      for (int t = 0; t < 20 && n < 3; t++) begin
         IV = 1'b1; IA = 8'h10 + 8'(n); IB = 8'(n); IOP = 2'b00;
         cycle();
         if (acc_last) n++;
      end
      chk("bp_accepted", 32'(n), 32'd3);
      chk("bp_ir_low", 32'(IR), 32'd0);
      chk("bp_head_od", 32'(OD), 32'h10);
      IA = 8'h13; IB = 8'h03;
      cycle();
      chk("bp_4th_stalled", 32'(acc_last), 32'd0);
      ORDY = 1'b1;
      cycle();
      chk("bp_4th_accepted", 32'(acc_last), 32'd1);
      drain();

      // Illegal op
      IV = 1'b1; IA = 8'h5A; IB = 8'h00; IOP = 2'b10;
      cycle();
      IV = 1'b0;
      cycle();
`ifdef IDVR_SHIFT_ERRDROP_EN
      chk("ill_drop_ov", 32'(OV), 32'd0);
`else
      chk("ill_ov", 32'(OV), 32'd1);
      chk("ill_od", 32'(OD), 32'h5A);
      chk("ill_oe", 32'(OE), 32'd1);
`endif
      chk("ill_ecnt", 32'(ECNT), 32'd1);
      drain();

      // ECNT saturation
      IV = 1'b1; IOP = 2'b10; ORDY = 1'b1;
      for (int t = 0; t < 300; t++) begin
         IA = 8'($urandom); IB = 8'($urandom);
         cycle();
      end
      drain();
      chk("ecnt_sat", 32'(ECNT), 32'hFF);

      // Random valid/ready traffic, ordering checked by scoreboard
      for (int t = 0; t < 200; t++) begin
         IV = 1'($urandom); ORDY = 1'($urandom);
         IA = 8'($urandom); IB = 8'($urandom); IOP = 2'($urandom);
         cycle();
      end
      drain();
      chk("ecnt_hold", 32'(ECNT), 32'hFF);

      // Reset mid-stream with FIFO full and S1 valid
      ORDY = 1'b0;
      n = 0;
      for (int t = 0; t < 20 && n < 3; t++) begin
         IV = 1'b1; IA = 8'h20 + 8'(n); IB = 8'h01; IOP = 2'b00;
         cycle();
         if (acc_last) n++;
      end
      chk("mid_full_ir", 32'(IR), 32'd0);
      RST = 1'b1;
      cycle();
      sb_q.delete();
      RST = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(OV), 32'd0);
      chk("mid_rst_ecnt", 32'(ECNT), 32'd0);
      chk("mid_rst_ir", 32'(IR), 32'd1);
      IV = 1'b0; ORDY = 1'b1;
      repeat (5) cycle();
      chk("mid_rst_quiet", 32'(OV), 32'd0);
      IV = 1'b1; IA = 8'h03; IB = 8'h02; IOP = 2'b00;
      cycle();
      IV = 1'b0;
      cycle();
      chk("recover_od", 32'(OD), 32'h0C);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
